// File: rtl/jtag_bus_pkg.sv
// Shared types and widths for the JTAG chain1 bus master stage.
package jtag_bus_pkg;

    localparam int ADDR_W  = 32;
    localparam int BE_W    = 4;
    localparam int BURST_W = 8;
    localparam int TMO_W   = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQUEST,
        S_BEGIN,
        S_READ,
        S_WRITE,
        S_ENDW,
        S_DONE,
        S_ERROR
    } state_t;

endpackage

// File: rtl/jtag_bus_timeout.sv
// Slave-response watchdog: loadable down-counter that flags the last permitted stall cycle.
module jtag_bus_timeout
    import jtag_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam logic [TMO_W-1:0] LOAD_VAL = TMO_W'(TIMEOUT_CYCLES);

    logic [TMO_W-1:0] count_q;

    always_ff @(posedge clock) begin
        if (reset || load) begin
            count_q <= LOAD_VAL;
        end else if (enable && (count_q != '0)) begin
            count_q <= count_q - TMO_W'(1);
        end
    end

    // Fires on the stall cycle that would bring the count to zero.
    assign expired = enable && (count_q <= TMO_W'(1));

endmodule

// File: rtl/jtag_bus_master.sv
// Executes the command captured by JTAG chain1 as one Gecko5 bus burst through the ping-pong buffer.
//   state   | meaning
//   IDLE    | waiting for cmd_start
//   REQUEST | requesting the bus from the arbiter
//   BEGIN   | begin strobe with address/byte enables/burst size
//   READ    | storing slave read beats into the buffer
//   WRITE   | sending buffer words as write beats
//   ENDW    | master end-of-burst strobe (write end or timeout)
//   DONE    | one-cycle done pulse
//   ERROR   | bus error or timeout, sets sticky error
module jtag_bus_master
    import jtag_bus_pkg::*;
#(
    parameter int BUF_AW         = 8,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cmd_start,
    input  logic               cmd_read,
    input  logic [ADDR_W-1:0]  cmd_address,
    input  logic [BE_W-1:0]    cmd_byte_enables,
    input  logic [BURST_W-1:0] cmd_burst_size,
    output logic               buf_wr_en,
    output logic [BUF_AW-1:0]  buf_wr_addr,
    output logic [ADDR_W-1:0]  buf_wr_data,
    output logic [BUF_AW-1:0]  buf_rd_addr,
    input  logic [ADDR_W-1:0]  buf_rd_data,
    output logic               requestTransaction,
    input  logic               transactionGranted,
    output logic               beginTransactionOut,
    output logic [ADDR_W-1:0]  addressDataOut,
    output logic [BE_W-1:0]    byteEnablesOut,
    output logic [BURST_W-1:0] burstSizeOut,
    output logic               readNotWriteOut,
    output logic               dataValidOut,
    output logic               endTransactionOut,
    input  logic [ADDR_W-1:0]  addressDataIn,
    input  logic               dataValidIn,
    input  logic               endTransactionIn,
    input  logic               busyIn,
    input  logic               busErrorIn,
    output logic               busy,
    output logic               done,
    output logic               error
);

    state_t             state_q, state_nxt;
    logic               cmd_rd_q;
    logic [ADDR_W-1:0]  cmd_addr_q;
    logic [BE_W-1:0]    cmd_be_q;
    logic [BURST_W-1:0] cmd_burst_q;
    logic [BURST_W-1:0] beat_q;
    logic [BURST_W-1:0] beat_inc;
    logic               full_q;
    logic               timed_out_q;
    logic               error_q;
    logic               beat_adv;
    logic               tmo_load, tmo_en, tmo_expired;

    assign beat_inc = beat_q + BURST_W'(1);

    jtag_bus_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .load   (tmo_load),
        .enable (tmo_en),
        .expired(tmo_expired)
    );

    always_comb begin
        tmo_load = 1'b1;
        tmo_en   = 1'b0;
        if (state_q == S_READ) begin
            tmo_en   = !dataValidIn && !endTransactionIn;
            tmo_load = !tmo_en;
        end else if (state_q == S_WRITE) begin
            tmo_en   = busyIn;
            tmo_load = !busyIn;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cmd_rd_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_be_q    <= '0;
            cmd_burst_q <= '0;
            beat_q      <= '0;
            full_q      <= 1'b0;
            timed_out_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q <= state_nxt;
            if (state_q == S_IDLE && cmd_start) begin
                cmd_rd_q    <= cmd_read;
                cmd_addr_q  <= cmd_address & ~ADDR_W'(3);
                cmd_be_q    <= cmd_byte_enables;
                cmd_burst_q <= cmd_burst_size;
                error_q     <= 1'b0;
            end
            if (state_q == S_BEGIN) begin
                beat_q      <= '0;
                full_q      <= 1'b0;
                timed_out_q <= 1'b0;
            end
            if (beat_adv) begin
                beat_q <= beat_inc;
                // Marks the burst complete so surplus read beats are dropped without wrapping.
                if (beat_q == cmd_burst_q) full_q <= 1'b1;
            end
            if ((state_q == S_READ || state_q == S_WRITE) && state_nxt == S_ENDW && tmo_expired) begin
                timed_out_q <= 1'b1;
            end
            if (state_q == S_ERROR) error_q <= 1'b1;
        end
    end

    always_comb begin
        state_nxt           = state_q;
        beat_adv            = 1'b0;
        buf_wr_en           = 1'b0;
        buf_wr_addr         = '0;
        buf_wr_data         = '0;
        buf_rd_addr         = '0;
        requestTransaction  = 1'b0;
        beginTransactionOut = 1'b0;
        addressDataOut      = '0;
        byteEnablesOut      = '0;
        burstSizeOut        = '0;
        readNotWriteOut     = 1'b0;
        dataValidOut        = 1'b0;
        endTransactionOut   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_start) state_nxt = S_REQUEST;
            end
            S_REQUEST: begin
                requestTransaction = 1'b1;
                if (transactionGranted) state_nxt = S_BEGIN;
            end
            S_BEGIN: begin
                beginTransactionOut = 1'b1;
                addressDataOut      = cmd_addr_q;
                byteEnablesOut      = cmd_be_q;
                burstSizeOut        = cmd_burst_q;
                readNotWriteOut     = cmd_rd_q;
                if (busErrorIn)    state_nxt = S_ERROR;
                else if (cmd_rd_q) state_nxt = S_READ;
                else               state_nxt = S_WRITE;
            end
            S_READ: begin
                if (busErrorIn) begin
                    state_nxt = S_ERROR;
                end else begin
                    buf_wr_en = dataValidIn && !full_q;
                    beat_adv  = buf_wr_en;
                    if (buf_wr_en) begin
                        buf_wr_addr = BUF_AW'(beat_q);
                        buf_wr_data = addressDataIn;
                    end
                    if (endTransactionIn) state_nxt = S_DONE;
                    else if (tmo_expired) state_nxt = S_ENDW;
                end
            end
            S_WRITE: begin
                dataValidOut   = 1'b1;
                addressDataOut = buf_rd_data;
                // Next word is prefetched unless the slave stalls, which re-reads the current one.
                buf_rd_addr    = busyIn ? BUF_AW'(beat_q) : BUF_AW'(beat_inc);
                if (busErrorIn) begin
                    state_nxt = S_ERROR;
                end else if (!busyIn) begin
                    beat_adv = 1'b1;
                    if (beat_q == cmd_burst_q) state_nxt = S_ENDW;
                end else if (tmo_expired) begin
                    state_nxt = S_ENDW;
                end
            end
            S_ENDW: begin
                endTransactionOut = 1'b1;
                state_nxt = timed_out_q ? S_ERROR : S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ERROR: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy  = (state_q != S_IDLE);
    assign done  = (state_q == S_DONE);
    assign error = error_q;

endmodule

// File: tb/tb_jtag_bus_master.sv
// Directed bench for jtag_bus_master with a behavioural ping-pong buffer model.
module tb_jtag_bus_master;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_start, cmd_read;
    logic [31:0] cmd_address;
    logic [3:0]  cmd_byte_enables;
    logic [7:0]  cmd_burst_size;
    logic        buf_wr_en;
    logic [7:0]  buf_wr_addr, buf_rd_addr;
    logic [31:0] buf_wr_data, buf_rd_data;
    logic        requestTransaction, transactionGranted, beginTransactionOut;
    logic [31:0] addressDataOut, addressDataIn;
    logic [3:0]  byteEnablesOut;
    logic [7:0]  burstSizeOut;
    logic        readNotWriteOut, dataValidOut, endTransactionOut;
    logic        dataValidIn, endTransactionIn, busyIn, busErrorIn;
    logic        busy, done, error;

    logic [31:0] buf_mem [256];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    jtag_bus_master #(.BUF_AW(8), .TIMEOUT_CYCLES(15)) dut (
        .clock(clock), .reset(reset),
        .cmd_start(cmd_start), .cmd_read(cmd_read), .cmd_address(cmd_address),
        .cmd_byte_enables(cmd_byte_enables), .cmd_burst_size(cmd_burst_size),
        .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
        .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
        .requestTransaction(requestTransaction), .transactionGranted(transactionGranted),
        .beginTransactionOut(beginTransactionOut), .addressDataOut(addressDataOut),
        .byteEnablesOut(byteEnablesOut), .burstSizeOut(burstSizeOut),
        .readNotWriteOut(readNotWriteOut), .dataValidOut(dataValidOut),
        .endTransactionOut(endTransactionOut), .addressDataIn(addressDataIn),
        .dataValidIn(dataValidIn), .endTransactionIn(endTransactionIn),
        .busyIn(busyIn), .busErrorIn(busErrorIn),
        .busy(busy), .done(done), .error(error)
    );

    // Buffer: synchronous write, one-cycle read latency.
    always @(posedge clock) begin
        if (buf_wr_en) buf_mem[buf_wr_addr] <= buf_wr_data;
        buf_rd_data <= buf_mem[buf_rd_addr];
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_slave();
        transactionGranted = 0; addressDataIn = '0; dataValidIn = 0;
        endTransactionIn = 0; busyIn = 0; busErrorIn = 0;
    endtask

    // Returns 1 ns after the edge that moves the DUT into REQUEST.
    task automatic issue(input logic rd, input logic [31:0] a, input logic [7:0] bs);
        step();
        cmd_start = 1; cmd_read = rd; cmd_address = a;
        cmd_byte_enables = 4'hF; cmd_burst_size = bs;
        step();
        cmd_start = 0;
    endtask

    initial begin
        reset = 1; cmd_start = 0; cmd_read = 0; cmd_address = '0;
        cmd_byte_enables = '0; cmd_burst_size = '0; buf_rd_data = '0;
        clear_slave();
        for (int i = 0; i < 256; i++) buf_mem[i] = '0;
        step(); step();
        reset = 0;
        #1;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst error", error, 0);
        chk("rst req", requestTransaction, 0);
        chk("rst begin", beginTransactionOut, 0);
        chk("rst addr", addressDataOut, 0);
        chk("rst bufwe", buf_wr_en, 0);

        // 1: read burst of 4, grant after 2 cycles
        issue(1, 32'h0000_1000, 8'd3);
        #1; chk("t1 req0", requestTransaction, 1); chk("t1 busy", busy, 1);
        step(); #1; chk("t1 req1", requestTransaction, 1);
        step(); transactionGranted = 1; #1; chk("t1 req2", requestTransaction, 1);
        step(); transactionGranted = 0; #1;
        chk("t1 begin", beginTransactionOut, 1);
        chk("t1 addr", addressDataOut, 32'h0000_1000);
        chk("t1 burst", burstSizeOut, 3);
        chk("t1 rnw", readNotWriteOut, 1);
        chk("t1 be", byteEnablesOut, 4'hF);
        chk("t1 req off", requestTransaction, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            dataValidIn = 1; addressDataIn = 32'hA0 + i; endTransactionIn = (i == 3);
            #1;
            chk("t1 we", buf_wr_en, 1);
            chk("t1 waddr", buf_wr_addr, i);
            chk("t1 wdata", buf_wr_data, 32'hA0 + i);
        end
        step(); clear_slave(); #1;
        chk("t1 done", done, 1); chk("t1 begin off", beginTransactionOut, 0);
        step(); #1;
        chk("t1 done pulse", done, 0); chk("t1 idle", busy, 0); chk("t1 error", error, 0);
        for (int i = 0; i < 4; i++) chk("t1 bufmem", buf_mem[i], 32'hA0 + i);

        // 2: write burst of 2 with a two-cycle stall on beat 0
        buf_mem[0] = 32'h1111_1111; buf_mem[1] = 32'h2222_2222;
        issue(0, 32'h0000_2000, 8'd1);
        transactionGranted = 1; #1; chk("t2 req", requestTransaction, 1);
        step(); transactionGranted = 0; #1;
        chk("t2 begin", beginTransactionOut, 1); chk("t2 rnw", readNotWriteOut, 0);
        chk("t2 rdaddr0", buf_rd_addr, 0);
        step(); busyIn = 1; #1;
        chk("t2 dv", dataValidOut, 1); chk("t2 d0 stall", addressDataOut, 32'h1111_1111);
        chk("t2 rdaddr hold", buf_rd_addr, 0);
        step(); #1; chk("t2 d0 stall2", addressDataOut, 32'h1111_1111);
        step(); busyIn = 0; #1;
        chk("t2 d0 go", addressDataOut, 32'h1111_1111); chk("t2 rdaddr1", buf_rd_addr, 1);
        step(); #1;
        chk("t2 dv1", dataValidOut, 1); chk("t2 d1", addressDataOut, 32'h2222_2222);
        chk("t2 end early", endTransactionOut, 0);
        step(); #1;
        chk("t2 endw", endTransactionOut, 1); chk("t2 dv off", dataValidOut, 0);
        step(); #1;
        chk("t2 done", done, 1); chk("t2 end off", endTransactionOut, 0);
        step(); #1; chk("t2 idle", busy, 0);

        // 3: read aborted by bus error on beat 1
        buf_mem[0] = '0; buf_mem[1] = '0;
        issue(1, 32'h0000_3000, 8'd3);
        transactionGranted = 1;
        step(); transactionGranted = 0;
        step(); dataValidIn = 1; addressDataIn = 32'hB0; #1; chk("t3 we0", buf_wr_en, 1);
        step(); addressDataIn = 32'hB1; busErrorIn = 1; #1; chk("t3 we1", buf_wr_en, 0);
        step(); clear_slave(); #1; chk("t3 err busy", busy, 1); chk("t3 no done", done, 0);
        step(); #1;
        chk("t3 error", error, 1); chk("t3 idle", busy, 0); chk("t3 done", done, 0);
        chk("t3 beat0", buf_mem[0], 32'hB0); chk("t3 beat1", buf_mem[1], 0);

        // 4: silent slave after begin; also checks that the new cmd_start clears error
        issue(1, 32'h0000_3000, 8'd0);
        #1; chk("t4 err clr", error, 0); chk("t4 busy", busy, 1);
        transactionGranted = 1;
        step(); transactionGranted = 0; #1; chk("t4 begin", beginTransactionOut, 1);
        for (int i = 1; i <= 15; i++) begin
            step(); #1;
            chk("t4 wait", endTransactionOut, 0);
        end
        step(); #1; chk("t4 end strobe", endTransactionOut, 1);
        step(); #1; chk("t4 no done", done, 0); chk("t4 errstate", busy, 1);
        step(); #1; chk("t4 error", error, 1); chk("t4 idle", busy, 0);

        // 5: cmd_start while busy is ignored; reset during WRITE
        issue(0, 32'h0000_4000, 8'd3);
        #1; chk("t5 req", requestTransaction, 1);
        step(); cmd_start = 1; cmd_read = 1; cmd_address = 32'h0000_5000; #1;
        step(); cmd_start = 0; transactionGranted = 1; #1;
        step(); transactionGranted = 0; #1;
        chk("t5 addr kept", addressDataOut, 32'h0000_4000);
        chk("t5 rnw kept", readNotWriteOut, 0);
        chk("t5 burst kept", burstSizeOut, 3);
        step(); #1; chk("t5 writing", dataValidOut, 1);
        step(); reset = 1; #1;
        step(); #1;
        chk("t5 rst dv", dataValidOut, 0); chk("t5 rst addr", addressDataOut, 0);
        chk("t5 rst busy", busy, 0); chk("t5 rst rdaddr", buf_rd_addr, 0);
        chk("t5 rst end", endTransactionOut, 0); chk("t5 rst error", error, 0);
        reset = 0;

        // 6: single-word read, unaligned address, valid and end together
        buf_mem[0] = '0;
        issue(1, 32'h0000_1003, 8'd0);
        transactionGranted = 1;
        step(); transactionGranted = 0; #1;
        chk("t6 addr", addressDataOut, 32'h0000_1000); chk("t6 burst", burstSizeOut, 0);
        step(); dataValidIn = 1; endTransactionIn = 1; addressDataIn = 32'hC0DE_0001; #1;
        chk("t6 we", buf_wr_en, 1); chk("t6 waddr", buf_wr_addr, 0);
        chk("t6 wdata", buf_wr_data, 32'hC0DE_0001);
        step(); clear_slave(); #1; chk("t6 done", done, 1);
        step(); #1;
        chk("t6 idle", busy, 0); chk("t6 error", error, 0);
        chk("t6 bufmem", buf_mem[0], 32'hC0DE_0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
